// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StFix,
      StDone
   } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the main controller (master) and muldiv_seq (slave).
interface muldiv_if import muldiv_pkg::*; #(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             Load_HI;
   logic             Load_LO;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, Load_HI, Load_LO, hi, lo, div_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, Load_HI, Load_LO, hi, lo, div_zero
   );

endinterface

// File: rtl/muldiv_core.sv
// One unsigned iteration: shift-add multiply step or restoring shift-subtract divide step.
// {acc_hi, acc_lo} holds product-so-far/multiplier or remainder/dividend-quotient.
module muldiv_core import muldiv_pkg::*; #(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             op_i,
   input  logic [WIDTH-1:0] acc_hi_i,
   input  logic [WIDTH-1:0] acc_lo_i,
   input  logic [WIDTH-1:0] operand_i,
   output logic [WIDTH-1:0] acc_hi_o,
   output logic [WIDTH-1:0] acc_lo_o
);

   logic [WIDTH:0] operand_ext;
   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // Single datapath step selected by the operation.
   always_comb begin
      operand_ext = {1'b0, operand_i};
      sum         = '0;
      shifted     = '0;
      diff        = '0;
      acc_hi_o    = acc_hi_i;
      acc_lo_o    = acc_lo_i;
      if (op_i == OP_MULT) begin
         // Add multiplicand when the current multiplier bit is set, then shift right.
         sum      = {1'b0, acc_hi_i} + (acc_lo_i[0] ? operand_ext : '0);
         acc_hi_o = sum[WIDTH:1];
         acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
      end else begin
         shifted = {acc_hi_i, acc_lo_i[WIDTH-1]};
         diff    = shifted - operand_ext;
         if (shifted >= operand_ext) begin
            acc_hi_o = diff[WIDTH-1:0];
            acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_hi_o = shifted[WIDTH-1:0];
            acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential signed multiply/divide unit with fixed WIDTH+2 cycle latency.
// Optional feature: define MULDIV_DIV0_TRAP_EN to short-circuit divide-by-zero
// straight to DONE with div_zero flagged.
module muldiv_seq import muldiv_pkg::*; #(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input logic     clk,
   input logic     reset_n,
   muldiv_if.slave bus
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             op_q, op_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             div_zero_q, div_zero_d;

   logic [WIDTH-1:0]   step_hi, step_lo;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [2*WIDTH-1:0] prod;

   muldiv_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op_i      (op_q),
      .acc_hi_i  (acc_hi_q),
      .acc_lo_i  (acc_lo_q),
      .operand_i (opnd_q),
      .acc_hi_o  (step_hi),
      .acc_lo_o  (step_lo)
   );

   // Next-state, operand capture, iteration and sign fix-up.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      sa_d       = sa_q;
      sb_d       = sb_q;
      opnd_d     = opnd_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;
      a_abs      = bus.a[WIDTH-1] ? -bus.a : bus.a;
      b_abs      = bus.b[WIDTH-1] ? -bus.b : bus.b;
      prod       = {acc_hi_q, acc_lo_q};
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               op_d     = bus.op;
               sa_d     = bus.a[WIDTH-1];
               sb_d     = bus.b[WIDTH-1];
               cnt_d    = CntW'(WIDTH);
               acc_hi_d = '0;
               // Divide iterates on the dividend; multiply iterates on the multiplier.
               acc_lo_d = (bus.op == OP_DIV) ? a_abs : b_abs;
               opnd_d   = (bus.op == OP_DIV) ? b_abs : a_abs;
               state_d  = StCalc;
`ifdef MULDIV_DIV0_TRAP_EN
               if (bus.op == OP_DIV && bus.b == '0) begin
                  hi_d       = bus.a;
                  lo_d       = '1;
                  div_zero_d = 1'b1;
                  state_d    = StDone;
               end
`endif
            end
         end
         StCalc: begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            cnt_d    = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            if (op_q == OP_MULT) begin
               if (sa_q ^ sb_q) begin
                  prod = -prod;
               end
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end else begin
               // Quotient truncates toward zero; remainder follows the dividend's sign.
               lo_d = (sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q;
               hi_d = sa_q ? -acc_hi_q : acc_hi_q;
            end
            div_zero_d = 1'b0;
            state_d    = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         op_q       <= OP_MULT;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         opnd_q     <= '0;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         sa_q       <= sa_d;
         sb_q       <= sb_d;
         opnd_q     <= opnd_d;
         acc_hi_q   <= acc_hi_d;
         acc_lo_q   <= acc_lo_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign bus.busy     = (state_q != StIdle);
   assign bus.done     = (state_q == StDone);
   assign bus.Load_HI  = bus.done;
   assign bus.Load_LO  = bus.done;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed table, multi-cycle corner sequences,
// and random operands against an arithmetic reference model.
module tb_muldiv_seq;

   localparam int W = 32;

`ifdef MULDIV_DIV0_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk;
   logic reset_n;
   int   n_vec;
   int   n_err;

   muldiv_if #(.WIDTH(W)) bus ();

   muldiv_seq #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain signed arithmetic; divide by zero follows the documented result.
   task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic dz, output int lat);
      longint p;
      longint q;
      longint r;
      dz  = 1'b0;
      lat = W + 2;
      if (op == 1'b0) begin
         p  = longint'($signed(a)) * longint'($signed(b));
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 32'd0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
         dz = TRAP;
         lat = TRAP ? 1 : W + 2;
      end else begin
         q  = longint'($signed(a)) / longint'($signed(b));
         r  = longint'($signed(a)) % longint'($signed(b));
         hi = r[31:0];
         lo = q[31:0];
      end
   endtask

   // Issue one op from an IDLE cycle and check its result in the DONE cycle.
   task automatic do_vec(input string tag, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input int elat);
      int cyc;
      chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
      chk({tag, " idle Load_HI"}, 32'(bus.Load_HI), 32'd0);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      tick();
      bus.start = 1'b0;
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < 100) begin
         tick();
         cyc++;
      end
      chk({tag, " latency"}, 32'(cyc), 32'(elat));
      chk({tag, " hi"}, bus.hi, ehi);
      chk({tag, " lo"}, bus.lo, elo);
      chk({tag, " div_zero"}, 32'(bus.div_zero), 32'(edz));
      chk({tag, " Load_HI"}, 32'(bus.Load_HI), 32'd1);
      chk({tag, " Load_LO"}, 32'(bus.Load_LO), 32'd1);
      chk({tag, " busy in done"}, 32'(bus.busy), 32'd1);
   endtask

   vec_t        tbl[11];
   logic [31:0] mhi, mlo;
   logic        mdz;
   int          mlat;
   int          cyc;
   int          dones;
   logic        rop;
   logic [31:0] ra, rb;

   initial begin
      n_vec = 0;
      n_err = 0;
      tbl[0]  = '{1'b0, 32'd6,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 34};
      tbl[1]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
      tbl[2]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0, 34};
      tbl[3]  = '{1'b1, 32'd7,        32'd0,        32'd7,        32'hFFFF_FFFF, TRAP,
                  TRAP ? 1 : 34};
      tbl[4]  = '{1'b0, 32'd3,        32'd4,        32'h0,        32'd12,        1'b0, 34};
      tbl[5]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        32'd1,         1'b0, 34};
      tbl[6]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        1'b0, 34};
      tbl[7]  = '{1'b1, 32'd100,      32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFF2, 1'b0, 34};
      tbl[8]  = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14,       1'b0, 34};
      tbl[9]  = '{1'b0, 32'h7FFF_FFFF, 32'd2,        32'h0,        32'hFFFF_FFFE, 1'b0, 34};
      tbl[10] = '{1'b1, 32'd5,        32'd10,       32'd5,        32'd0,         1'b0, 34};

      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      reset_n   = 1'b0;
      tick();
      tick();
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset Load_HI", 32'(bus.Load_HI), 32'd0);
      chk("reset Load_LO", 32'(bus.Load_LO), 32'd0);
      chk("reset hi", bus.hi, 32'd0);
      chk("reset lo", bus.lo, 32'd0);
      chk("reset div_zero", 32'(bus.div_zero), 32'd0);
      reset_n = 1'b1;
      tick();

      // Directed table, issued back-to-back (start in the first IDLE cycle after DONE).
      for (int i = 0; i < 11; i++) begin
         do_vec($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo,
                tbl[i].dz, tbl[i].lat);
         tick();
      end

      // Starts while busy and in the DONE cycle must be ignored.
      bus.start = 1'b1;
      bus.op    = 1'b0;
      bus.a     = 32'd6;
      bus.b     = 32'hFFFF_FFF9;
      tick();
      bus.start = 1'b0;
      cyc   = 1;
      dones = 0;
      while (bus.done !== 1'b1 && cyc < 100) begin
         if (cyc == 5 || cyc == 33) begin
            bus.start = 1'b1;
            bus.op    = 1'b1;
            bus.a     = 32'd100;
            bus.b     = 32'd3;
         end
         tick();
         bus.start = 1'b0;
         cyc++;
      end
      chk("busy-rej latency", 32'(cyc), 32'd34);
      chk("busy-rej hi", bus.hi, 32'hFFFF_FFFF);
      chk("busy-rej lo", bus.lo, 32'hFFFF_FFD6);
      bus.start = 1'b1;
      bus.op    = 1'b0;
      bus.a     = 32'd3;
      bus.b     = 32'd3;
      tick();
      bus.start = 1'b0;
      chk("done-start ignored busy", 32'(bus.busy), 32'd0);
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1) dones++;
         tick();
      end
      chk("done-start no extra done", 32'(dones), 32'd0);
      chk("hold hi", bus.hi, 32'hFFFF_FFFF);
      chk("hold lo", bus.lo, 32'hFFFF_FFD6);

      // Reset in the middle of an operation.
      bus.start = 1'b1;
      bus.op    = 1'b0;
      bus.a     = 32'h1234_5678;
      bus.b     = 32'h10;
      tick();
      bus.start = 1'b0;
      for (int i = 1; i < 10; i++) tick();
      reset_n = 1'b0;
      #1;
      chk("midrst busy", 32'(bus.busy), 32'd0);
      chk("midrst done", 32'(bus.done), 32'd0);
      chk("midrst Load_HI", 32'(bus.Load_HI), 32'd0);
      chk("midrst hi", bus.hi, 32'd0);
      chk("midrst lo", bus.lo, 32'd0);
      chk("midrst div_zero", 32'(bus.div_zero), 32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1) dones++;
         tick();
      end
      chk("midrst no done", 32'(dones), 32'd0);
      do_vec("post-reset", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34);
      tick();

      // Random operands against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         rop = 1'($urandom_range(1, 0));
         ra  = $urandom;
         rb  = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(15, 0)) : $urandom;
         if (i % 5 == 0) ra = ra >> $urandom_range(31, 0);
         if (rop == 1'b1 && rb == 32'd0) rb = 32'd1;
         model(rop, ra, rb, mhi, mlo, mdz, mlat);
         do_vec($sformatf("rnd%0d op%0d a=%h b=%h", i, rop, ra, rb), rop, ra, rb, mhi, mlo,
                mdz, mlat);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
